player_ctrl_fsm: RTL and testbench
==================================

Name: player_ctrl_fsm

Overview:
- Parametrised next-generation player controller, clocked once per video frame by frame_clk.
- Owns horizontal position, facing direction, lives, and the hit/death/respawn lifecycle.
- Sprite ROM lookup and pixel compositing are out of scope; this block feeds the sprite renderer and game-state logic.
- Differs from the previous player block as follows:
  - Bounds and step take effect in the same frame (no one-frame-late step).
  - All four keycode slots are scanned.
  - Adds a lives counter, a post-hit freeze, and an invulnerability window.

Parameters:
- X_W, 10, position width in bits.
- X_CENTER, 320, spawn/reset X.
- X_MIN, 10, left screen limit.
- X_MIN_WALL, 130, left limit when the wall is active.
- X_MAX, 590, right screen limit.
- SPRITE_W, 43, sprite width used in bound checks.
- STEP, 2, pixels per frame.
- WALL_LVL_LO, 4, first level with the wall.
- WALL_LVL_HI, 6, last level with the wall.
- LIVES, 3, lives at game start.
- LIVES_W, 2, width of the lives output.
- DEATH_FRAMES, 60, frames frozen after a hit.
- INVULN_FRAMES, 120, frames collision is ignored after respawn.
- KEY_LEFT, 8'h50, left keycode.
- KEY_RIGHT, 8'h4F, right keycode.

Ports:
- frame_clk  in  1  frame-rate clock.
- Reset_n  in  1  asynchronous, active-low reset (the codebase Reset, active-low polarity).
- keycode  in  4x8  the four keyboard slots (keycode..keycode4).
- game_on  in  2  0 = menu, 1 = play, 2/3 = pause.
- level  in  10  current level.
- collision  in  1  ball/player overlap, sampled each frame.
- PlayerX  out  X_W  player left-reference X.
- facing  out  2  0 = FORWARD, 1 = LEFT, 2 = RIGHT.
- pstate  out  3  FSM state code.
- lives  out  LIVES_W  remaining lives.
- blink_hide  out  1  renderer should suppress the sprite this frame.
- game_over  out  1  high in OVER.

Behaviour:
- Reset (Reset_n = 0, asynchronous) sets:
  - PlayerX = X_CENTER, facing = FORWARD, pstate = IDLE.
  - lives = LIVES, timer = 0, blink_hide = 0, game_over = 0.
- States and transitions:
  - IDLE: held while game_on == 0. PlayerX = X_CENTER, lives = LIVES, facing = FORWARD. Goes to ALIVE when game_on == 1.
  - ALIVE: key-driven motion. If collision = 1, goes to HIT, lives decrements, timer = DEATH_FRAMES - 1, and there is no motion that frame.
  - HIT: position frozen, timer decrements each frame. When timer == 0:
    - lives == 0 goes to OVER;
    - otherwise goes to INVULN with PlayerX = X_CENTER and timer = INVULN_FRAMES - 1.
  - INVULN: motion as in ALIVE, collision ignored, timer decrements. When timer == 0, goes to ALIVE.
  - OVER: frozen, game_over = 1. Exits only to IDLE via game_on == 0.
  - game_on == 0 in any state forces IDLE on the next edge.
  - game_on of 2 or 3 freezes state, timer and position in every state except IDLE.
- Key decode:
  - L = any slot equals KEY_LEFT; R = any slot equals KEY_RIGHT.
  - L only: move left, facing = LEFT.
  - R only: move right, facing = RIGHT.
  - Both or neither: no motion, facing = FORWARD.
  - facing updates in ALIVE and INVULN only; it holds in HIT, OVER and pause.
- Bounds, all combinational from the current inputs and applied in the same frame:
  - wall = (WALL_LVL_LO <= level <= WALL_LVL_HI).
  - lo = (wall ? X_MIN_WALL : X_MIN) + SPRITE_W.
  - hi = X_MAX - SPRITE_W.
  - Next X = clamp(PlayerX +/- STEP, lo, hi), computed in X_W + 1 bits with no wrap.
  - If the wall activates while PlayerX < lo, PlayerX snaps to lo on the next ALIVE/INVULN frame, regardless of keys.
- Lives saturate at 0; a decrement below 0 never happens.
- blink_hide = (pstate == INVULN) & timer[3]. It is 0 in all other states.
- All outputs are registered (1-frame latency from input to output), except:
  - game_over is decoded from pstate;
  - blink_hide is decoded from pstate and timer.
- Asynchronous reset mid-HIT or mid-INVULN returns to the full reset values immediately.

Decomposition:
- player_pkg holds:
  - the pstate_t enum (IDLE = 0, ALIVE = 1, HIT = 2, INVULN = 3, OVER = 4);
  - the facing_t enum;
  - the default KEY_LEFT/KEY_RIGHT constants;
  - the GAME_MENU, GAME_PLAY and GAME_PAUSE encodings.
- One sub-module, frame_timer:
  - loadable down-counter (load, value, enable, zero flag);
  - shared by HIT and INVULN; width = clog2(max(DEATH_FRAMES, INVULN_FRAMES)).

Test Plan:
1. Reset, then game_on = 1, then keycode[2] = 8'h4F for 10 frames -> PlayerX = 340, facing = RIGHT; keys released -> facing = FORWARD, PlayerX = 340.
2. level = 5, PlayerX driven left from 320 -> settles at exactly 173 and never goes below. level = 1 -> moves further, stops at 53. Holding right -> stops at 547.
3. keycode[0] = 8'h50 and keycode[3] = 8'h4F together -> PlayerX unchanged, facing = FORWARD.
4. In ALIVE, collision pulse -> next frame HIT, lives = 2, PlayerX frozen for 60 frames, then INVULN with PlayerX = 320. blink_hide toggles every 8 frames. A collision during INVULN is ignored. ALIVE resumes after 120 frames.
5. Three hits -> after the third HIT timeout, pstate = OVER, game_over = 1, lives = 0. game_on = 0 -> IDLE, lives = 3.
6. game_on = 2 mid-HIT for 20 frames -> timer held; resume -> HIT lasts 60 active frames in total. Reset_n asserted mid-INVULN -> immediate reset values.

Source files
------------

// File: rtl/player_pkg.sv
// -----------------------------------------------------------------------------
// player_pkg
// Shared types and constants for the player controller.
//   pstate_t  : lifecycle state codes, visible on the pstate output.
//   facing_t  : sprite facing direction.
//   KEY_*_DEF : default movement keycodes.
//   GAME_*    : game_on encodings (any value with bit 1 set is a pause).
//   max_int   : constant-expression helper for sizing the frame timer.
// -----------------------------------------------------------------------------
package player_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIVE  = 3'd1,
    HIT    = 3'd2,
    INVULN = 3'd3,
    OVER   = 3'd4
  } pstate_t;

  typedef enum logic [1:0] {
    FORWARD = 2'd0,
    LEFT    = 2'd1,
    RIGHT   = 2'd2
  } facing_t;

  localparam logic [7:0] KEY_LEFT_DEF  = 8'h50;
  localparam logic [7:0] KEY_RIGHT_DEF = 8'h4F;

  localparam logic [1:0] GAME_MENU  = 2'd0;
  localparam logic [1:0] GAME_PLAY  = 2'd1;
  localparam logic [1:0] GAME_PAUSE = 2'd2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/player_ctrl_fsm_frame_timer.sv
// -----------------------------------------------------------------------------
// frame_timer
// Loadable down-counter shared by the HIT freeze and the INVULN window.
// Ports:
//   clk, rst_n : frame clock, asynchronous active-low reset (count clears to 0)
//   i_load     : load i_value this frame (takes priority over i_en)
//   i_value    : value to load
//   i_en       : decrement this frame; the count stops at zero
//   o_count    : current count
//   o_zero     : count is zero
// -----------------------------------------------------------------------------
module frame_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/player_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// player_ctrl_fsm
// Per-frame player controller: horizontal position, facing, lives and the
// hit -> freeze -> respawn -> invulnerable lifecycle. Feeds the sprite
// renderer and game-state logic.
// Ports:
//   frame_clk  : frame-rate clock
//   Reset_n    : asynchronous active-low reset
//   keycode    : four keyboard slots, all scanned for the movement keys
//   game_on    : 0 menu, 1 play, 2/3 pause
//   level      : current level (selects the left wall)
//   collision  : ball/player overlap for this frame
//   PlayerX    : player left-reference X (registered)
//   facing     : 0 forward, 1 left, 2 right (registered)
//   pstate     : lifecycle state code (registered)
//   lives      : remaining lives (registered)
//   blink_hide : suppress the sprite this frame (INVULN blink)
//   game_over  : high while in OVER
// -----------------------------------------------------------------------------
module player_ctrl_fsm
  import player_pkg::*;
#(
  parameter int         X_W           = 10,
  parameter int         X_CENTER      = 320,
  parameter int         X_MIN         = 10,
  parameter int         X_MIN_WALL    = 130,
  parameter int         X_MAX         = 590,
  parameter int         SPRITE_W      = 43,
  parameter int         STEP          = 2,
  parameter int         WALL_LVL_LO   = 4,
  parameter int         WALL_LVL_HI   = 6,
  parameter int         LIVES         = 3,
  parameter int         LIVES_W       = 2,
  parameter int         DEATH_FRAMES  = 60,
  parameter int         INVULN_FRAMES = 120,
  parameter logic [7:0] KEY_LEFT      = KEY_LEFT_DEF,
  parameter logic [7:0] KEY_RIGHT     = KEY_RIGHT_DEF
) (
  input  logic               frame_clk,
  input  logic               Reset_n,
  input  logic [3:0][7:0]    keycode,
  input  logic [1:0]         game_on,
  input  logic [9:0]         level,
  input  logic               collision,
  output logic [X_W-1:0]     PlayerX,
  output logic [1:0]         facing,
  output logic [2:0]         pstate,
  output logic [LIVES_W-1:0] lives,
  output logic               blink_hide,
  output logic               game_over
);

  localparam int TIMER_W = $clog2(max_int(DEATH_FRAMES, INVULN_FRAMES));

  // Bounds are kept one bit wider than X so +/- STEP never wraps.
  localparam logic [X_W:0] LO_OPEN = (X_W + 1)'(X_MIN + SPRITE_W);
  localparam logic [X_W:0] LO_WALL = (X_W + 1)'(X_MIN_WALL + SPRITE_W);
  localparam logic [X_W:0] HI_LIM  = (X_W + 1)'(X_MAX - SPRITE_W);
  localparam logic [X_W:0] STEP_W  = (X_W + 1)'(STEP);

  pstate_t            r_state;
  facing_t            r_face;
  logic [X_W-1:0]     r_x;
  logic [LIVES_W-1:0] r_lives;

  logic               w_left, w_right, w_wall, w_pause;
  facing_t            w_dir;
  logic [X_W:0]       w_lo, w_x, w_cand, w_next_x;
  logic               w_t_load, w_t_en, w_t_zero;
  logic [TIMER_W-1:0] w_t_val, w_t_count;

  // Key scan over all four slots.
  // NOTE: combinational blocks use blocking '=' so later lines see earlier
  // results; registers use '<=' so every flop samples pre-edge values.
  always_comb begin
    w_left  = 1'b0;
    w_right = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (keycode[i] == KEY_LEFT)  w_left  = 1'b1;
      if (keycode[i] == KEY_RIGHT) w_right = 1'b1;
    end
  end

  assign w_dir   = (w_left && !w_right) ? LEFT :
                   (w_right && !w_left) ? RIGHT : FORWARD;
  assign w_wall  = (level >= 10'(WALL_LVL_LO)) && (level <= 10'(WALL_LVL_HI));
  assign w_lo    = w_wall ? LO_WALL : LO_OPEN;
  assign w_pause = (game_on & GAME_PAUSE) != 2'b00;
  assign w_x     = {1'b0, r_x};

  // Step and clamp against the bounds of this very frame. Clamping even with
  // no key held is what snaps the player out of a freshly raised wall.
  always_comb begin
    // NOTE: every path assigns a default first, so no latch is inferred.
    w_cand   = w_x;
    w_next_x = w_x;
    unique case (w_dir)
      LEFT:    w_cand = (w_x >= w_lo + STEP_W) ? (w_x - STEP_W) : w_lo;
      RIGHT:   w_cand = w_x + STEP_W;
      default: w_cand = w_x;
    endcase
    if (w_cand < w_lo)       w_next_x = w_lo;
    else if (w_cand > HI_LIM) w_next_x = HI_LIM;
    else                      w_next_x = w_cand;
  end

  // Timer control mirrors the state decisions made in the FSM below.
  always_comb begin
    w_t_load = 1'b0;
    w_t_val  = '0;
    w_t_en   = 1'b0;
    if (game_on == GAME_MENU) begin
      w_t_load = 1'b1;
    end else if (!w_pause) begin
      unique case (r_state)
        ALIVE: begin
          if (collision) begin
            w_t_load = 1'b1;
            w_t_val  = TIMER_W'(DEATH_FRAMES - 1);
          end
        end
        HIT: begin
          if (!w_t_zero)              w_t_en = 1'b1;
          else if (r_lives != '0) begin
            w_t_load = 1'b1;
            w_t_val  = TIMER_W'(INVULN_FRAMES - 1);
          end
        end
        INVULN:  w_t_en = 1'b1;
        default: ;
      endcase
    end
  end

  frame_timer #(.W(TIMER_W)) u_timer (
    .clk     (frame_clk),
    .rst_n   (Reset_n),
    .i_load  (w_t_load),
    .i_value (w_t_val),
    .i_en    (w_t_en),
    .o_count (w_t_count),
    .o_zero  (w_t_zero)
  );

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_x     <= X_W'(X_CENTER);
      r_face  <= FORWARD;
      r_lives <= LIVES_W'(LIVES);
    end else if (game_on == GAME_MENU) begin
      r_state <= IDLE;
      r_x     <= X_W'(X_CENTER);
      r_face  <= FORWARD;
      r_lives <= LIVES_W'(LIVES);
    end else if (r_state == IDLE) begin
      if (game_on == GAME_PLAY) r_state <= ALIVE;
    end else if (!w_pause) begin
      unique case (r_state)
        ALIVE: begin
          r_face <= w_dir;
          if (collision) begin
            r_state <= HIT;
            if (r_lives != '0) r_lives <= r_lives - LIVES_W'(1);
          end else begin
            r_x <= w_next_x[X_W-1:0];
          end
        end
        HIT: begin
          if (w_t_zero) begin
            if (r_lives == '0) begin
              r_state <= OVER;
            end else begin
              r_state <= INVULN;
              r_x     <= X_W'(X_CENTER);
            end
          end
        end
        INVULN: begin
          r_face <= w_dir;
          r_x    <= w_next_x[X_W-1:0];
          if (w_t_zero) r_state <= ALIVE;
        end
        default: ;
      endcase
    end
  end

  assign PlayerX    = r_x;
  assign facing     = r_face;
  assign pstate     = r_state;
  assign lives      = r_lives;
  assign game_over  = (r_state == OVER);
  assign blink_hide = (r_state == INVULN) && w_t_count[3];

endmodule

// File: tb/tb_player_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_player_ctrl_fsm
// Directed bench for player_ctrl_fsm. A frame-level model tracks phase, the
// number of frames spent in the current phase, position, facing and lives;
// a compare process checks every DUT output against it on each falling edge.
// Literal expectations at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_player_ctrl_fsm;

  localparam int X_CENTER      = 320;
  localparam int X_MIN         = 10;
  localparam int X_MIN_WALL    = 130;
  localparam int X_MAX         = 590;
  localparam int SPRITE_W      = 43;
  localparam int STEP          = 2;
  localparam int LIVES         = 3;
  localparam int DEATH_FRAMES  = 60;
  localparam int INVULN_FRAMES = 120;

  localparam int P_IDLE = 0, P_ALIVE = 1, P_HIT = 2, P_INVULN = 3, P_OVER = 4;

  logic            frame_clk = 1'b0;
  logic            Reset_n;
  logic [3:0][7:0] keycode;
  logic [1:0]      game_on;
  logic [9:0]      level;
  logic            collision;
  logic [9:0]      PlayerX;
  logic [1:0]      facing;
  logic [2:0]      pstate;
  logic [1:0]      lives;
  logic            blink_hide;
  logic            game_over;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  typedef struct {
    int ph;
    int x;
    int face;
    int lives;
    int age;   // frames already spent in the current phase
  } mstate_t;

  mstate_t m;

  always #5 frame_clk = ~frame_clk;

  player_ctrl_fsm dut (
    .frame_clk  (frame_clk),
    .Reset_n    (Reset_n),
    .keycode    (keycode),
    .game_on    (game_on),
    .level      (level),
    .collision  (collision),
    .PlayerX    (PlayerX),
    .facing     (facing),
    .pstate     (pstate),
    .lives      (lives),
    .blink_hide (blink_hide),
    .game_over  (game_over)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic mstate_t reset_state();
    mstate_t s;
    s.ph = P_IDLE; s.x = X_CENTER; s.face = 0; s.lives = LIVES; s.age = 0;
    return s;
  endfunction

  // One frame of the game rules, read straight from the behaviour description.
  function automatic mstate_t model_next(input mstate_t s);
    mstate_t n;
    int lo, hi, dir, delta;
    bit l, r;
    n = s;
    l = 1'b0;
    r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (keycode[i] == 8'h50) l = 1'b1;
      if (keycode[i] == 8'h4F) r = 1'b1;
    end
    dir   = (l && !r) ? 1 : (r && !l) ? 2 : 0;
    delta = (dir == 1) ? -STEP : (dir == 2) ? STEP : 0;
    lo    = ((level >= 4 && level <= 6) ? X_MIN_WALL : X_MIN) + SPRITE_W;
    hi    = X_MAX - SPRITE_W;
    if (game_on == 2'd0) begin
      n = reset_state();
    end else if (s.ph == P_IDLE) begin
      if (game_on == 2'd1) n.ph = P_ALIVE;
    end else if (game_on == 2'd1) begin
      case (s.ph)
        P_ALIVE: begin
          n.face = dir;
          if (collision) begin
            n.ph    = P_HIT;
            n.age   = 0;
            n.lives = (s.lives > 0) ? s.lives - 1 : 0;
          end else begin
            n.x = clampi(s.x + delta, lo, hi);
          end
        end
        P_HIT: begin
          if (s.age == DEATH_FRAMES - 1) begin
            if (s.lives == 0) begin
              n.ph = P_OVER;
            end else begin
              n.ph  = P_INVULN;
              n.x   = X_CENTER;
              n.age = 0;
            end
          end else begin
            n.age = s.age + 1;
          end
        end
        P_INVULN: begin
          n.face = dir;
          n.x    = clampi(s.x + delta, lo, hi);
          if (s.age == INVULN_FRAMES - 1) n.ph = P_ALIVE;
          else                            n.age = s.age + 1;
        end
        default: ;
      endcase
    end
    return n;
  endfunction

  always @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) m <= reset_state();
    else          m <= model_next(m);
  end

  // Blink follows bit 3 of the frames remaining in the window.
  function automatic int exp_blink();
    if (m.ph != P_INVULN) return 0;
    return ((INVULN_FRAMES - 1 - m.age) / 8) % 2;
  endfunction

  always @(negedge frame_clk) begin
    if (cmp_en) begin
      check("m_x",         int'(PlayerX),    m.x);
      check("m_facing",    int'(facing),     m.face);
      check("m_pstate",    int'(pstate),     m.ph);
      check("m_lives",     int'(lives),      m.lives);
      check("m_blink",     int'(blink_hide), exp_blink());
      check("m_game_over", int'(game_over),  int'(m.ph == P_OVER));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge frame_clk);
  endtask

  initial begin
    Reset_n   = 1'b1;
    keycode   = '0;
    game_on   = 2'd0;
    level     = 10'd1;
    collision = 1'b0;
    #1 Reset_n = 1'b0;
    #2;
    check("rst_x",         int'(PlayerX),    320);
    check("rst_facing",    int'(facing),     0);
    check("rst_pstate",    int'(pstate),     0);
    check("rst_lives",     int'(lives),      3);
    check("rst_blink",     int'(blink_hide), 0);
    check("rst_game_over", int'(game_over),  0);

    @(negedge frame_clk);
    Reset_n = 1'b1;
    cmp_en  = 1'b1;

    // Start play, walk right for ten frames.
    game_on = 2'd1;
    tick(1);
    check("t1_alive", int'(pstate), 1);
    keycode[2] = 8'h4F;
    tick(10);
    check("t1_x340",   int'(PlayerX), 340);
    check("t1_face_r", int'(facing),  2);
    keycode = '0;
    tick(1);
    check("t1_face_f", int'(facing),  0);
    check("t1_x_hold", int'(PlayerX), 340);

    // Left wall at level 5, open screen at level 1, snap, right edge.
    level      = 10'd5;
    keycode[1] = 8'h50;
    tick(100);
    check("t2_wall_173", int'(PlayerX), 173);
    check("t2_face_l",   int'(facing),  1);
    level = 10'd1;
    tick(70);
    check("t2_open_53", int'(PlayerX), 53);
    keycode = '0;
    level   = 10'd5;
    tick(1);
    check("t2_snap_173", int'(PlayerX), 173);
    level      = 10'd1;
    keycode[3] = 8'h4F;
    tick(260);
    check("t2_right_547", int'(PlayerX), 547);

    // Both keys held: no motion, facing forward.
    keycode[0] = 8'h50;
    tick(3);
    check("t3_both_x",    int'(PlayerX), 547);
    check("t3_both_face", int'(facing),  0);

    // First hit, freeze, respawn, blink, ignored collision.
    keycode   = '0;
    collision = 1'b1;
    tick(1);
    collision = 1'b0;
    check("t4_hit",    int'(pstate), 2);
    check("t4_lives2", int'(lives),  2);
    keycode[0] = 8'h50;
    tick(10);
    keycode = '0;
    check("t4_frozen_x",    int'(PlayerX), 547);
    check("t4_frozen_face", int'(facing),  0);
    tick(49);
    check("t4_still_hit", int'(pstate), 2);
    tick(1);
    check("t4_invuln",   int'(pstate),     3);
    check("t4_respawn",  int'(PlayerX),    320);
    check("t4_blink_lo", int'(blink_hide), 0);
    tick(8);
    check("t4_blink_hi", int'(blink_hide), 1);
    tick(8);
    check("t4_blink_lo2", int'(blink_hide), 0);
    collision = 1'b1;
    tick(1);
    collision = 1'b0;
    check("t4_ignore_coll", int'(pstate), 3);
    check("t4_ignore_life", int'(lives),  2);
    tick(102);
    check("t4_invuln_end", int'(pstate), 3);
    tick(1);
    check("t4_alive_again", int'(pstate), 1);

    // Two more hits end the game.
    collision = 1'b1;
    tick(1);
    collision = 1'b0;
    check("t5_lives1", int'(lives), 1);
    tick(60);
    check("t5_invuln", int'(pstate), 3);
    tick(120);
    check("t5_alive", int'(pstate), 1);
    collision = 1'b1;
    tick(1);
    collision = 1'b0;
    check("t5_lives0", int'(lives), 0);
    tick(60);
    check("t5_over",      int'(pstate),    4);
    check("t5_game_over", int'(game_over), 1);
    collision = 1'b1;
    tick(2);
    collision = 1'b0;
    check("t5_over_hold", int'(pstate), 4);
    game_on = 2'd0;
    tick(1);
    check("t5_idle",       int'(pstate), 0);
    check("t5_lives_back", int'(lives),  3);

    // Pause mid-HIT, then asynchronous reset mid-INVULN.
    game_on = 2'd1;
    tick(1);
    collision = 1'b1;
    tick(1);
    collision = 1'b0;
    check("t6_hit", int'(pstate), 2);
    tick(10);
    game_on = 2'd2;
    tick(20);
    check("t6_paused_hit", int'(pstate), 2);
    game_on = 2'd1;
    tick(49);
    check("t6_hit_59", int'(pstate), 2);
    tick(1);
    check("t6_invuln_60", int'(pstate), 3);
    keycode[1] = 8'h50;
    tick(5);
    #2 Reset_n = 1'b0;
    #1;
    check("t6_arst_pstate", int'(pstate),     0);
    check("t6_arst_x",      int'(PlayerX),    320);
    check("t6_arst_lives",  int'(lives),      3);
    check("t6_arst_facing", int'(facing),     0);
    check("t6_arst_blink",  int'(blink_hide), 0);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    keycode = '0;
    tick(2);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
